axis_rr_arbiter: RTL
====================

# axis_rr_arbiter

Packet-level round-robin arbiter sharing one AXI-Stream master port between NUM_SRC stream sources (power-of-3 generators and similar stream producers). It grants one source at a time, forwards its beats through a registered output stage, and releases the grant on tlast or a forced beat-count limit. It sits between the generator bank and the downstream consumer (FIFO/DMA).

## Interface

Parameters:
- DATA_SIZE, 32, tdata width; multiple of 8
- NUM_SRC, 4, number of sources; 2..8
- MAX_BEATS, 256, beat limit per grant before forced tlast; 1..65535

Ports:
- axis_aclk  in  1  single clock, all logic on rising edge
- axis_areset  in  1  synchronous reset, active-high
- src_enable  in  NUM_SRC  per-source arbitration mask; 1 = eligible
- s_axis_tdata  in  NUM_SRC*DATA_SIZE  source data, source i at [i*DATA_SIZE +: DATA_SIZE]
- s_axis_tstrb  in  NUM_SRC*DATA_SIZE/8  source strobes, same packing
- s_axis_tvalid  in  NUM_SRC  source valid
- s_axis_tlast  in  NUM_SRC  source end-of-packet
- s_axis_tready  out  NUM_SRC  source ready; at most one bit high
- m00_axis_tdata  out  DATA_SIZE  output data (registered)
- m00_axis_tstrb  out  DATA_SIZE/8  output strobe (registered)
- m00_axis_tvalid  out  1  output valid (registered)
- m00_axis_tlast  out  1  output last (registered)
- m00_axis_tready  in  1  downstream ready
- grant_id  out  clog2(NUM_SRC)  currently/last granted source
- busy  out  1  high while in BUSY state
- forced_last  out  1  one-cycle pulse when a grant ends on MAX_BEATS

## Operation

- States: IDLE, BUSY.
- IDLE: request vector = s_axis_tvalid & src_enable. If nonzero, pick first set bit searching from (grant_id+1) mod NUM_SRC upward with wrap; register grant_id, go BUSY, clear beat counter. If zero, stay IDLE.
- BUSY: s_axis_tready[grant_id] = m00_axis_tready | ~m00_axis_tvalid; all other s_axis_tready bits 0. On source handshake, load output register with granted tdata/tstrb/tlast, set m00_axis_tvalid, increment beat counter.
- Output register: on m00 handshake without new source beat, m00_axis_tvalid clears. Data held stable while tvalid & ~tready.
- Grant release: source beat with tlast=1 accepted -> IDLE. Beat number MAX_BEATS accepted without tlast -> m00_axis_tlast forced 1 on that beat, forced_last pulses next cycle, -> IDLE; remaining source beats form a new packet after re-arbitration.
- src_enable deasserted for the granted source mid-packet: no effect until release (no abort).
- Source drops tvalid mid-packet: arbiter waits in BUSY; no timeout.
- Beat counter width clog2(MAX_BEATS+1); never wraps (cleared on grant).
- Reset values: state IDLE, grant_id NUM_SRC-1 (so source 0 wins first), m00_axis_tvalid/tlast/tdata/tstrb 0, s_axis_tready 0, busy 0, forced_last 0, beat counter 0.
- Reset mid-packet: all of the above immediately on the reset edge; in-flight output beat discarded.

## Timing

- Request seen in IDLE at cycle 0 -> grant registered at edge 1, s_axis_tready high in cycle 1 (if output can accept) -> beat on m00 from cycle 2. Arbitration latency 1 cycle, forwarding latency 1 cycle.
- Steady state in BUSY: one beat per cycle with m00_axis_tready held high.
- After a releasing beat: one IDLE cycle (bubble) before next grant; back-to-back single-beat packets give 50% throughput.
- s_axis_tready depends combinationally on m00_axis_tready and registered state only; never on s_axis_tvalid.

## Structure

- Package axis_arb_pkg: state enum (IDLE, BUSY), NUM_SRC_MAX = 8, clog2 helper function.
- Sub-module rr_priority_pick: combinational rotate-priority selector (request vector, pointer -> one-hot grant + index); instantiated once.

## Test plan

- Single source 0, 3-beat packet (tdata 1,3,9, tlast on beat 3), tready=1 -> m00 shows 1,3,9 in cycles 2-4, tlast only on 9, grant_id=0, returns IDLE.
- All 4 sources valid with 1-beat packets (generator style tlast=1) -> grant order 0,1,2,3,0; one idle cycle between grants.
- MAX_BEATS=4, source 2 streams 6 beats with tlast on beat 6 -> m00 tlast on beats 4 and 6, forced_last pulse once after beat 4, re-grant to 2 if alone.
- m00_axis_tready low for 3 cycles mid-packet -> m00 tdata/tvalid held constant, s_axis_tready low, no beat lost or duplicated.
- src_enable=4'b1010 with all sources valid -> only sources 1 and 3 granted, alternating; clearing bit 1 mid-packet completes that packet first.
- Assert axis_areset during beat 2 of a packet -> next cycle all outputs at reset values; first grant afterwards goes to lowest valid source.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream round-robin arbiter.
// Latency: none (package only).
// Backpressure: n/a.
package axis_arb_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam int NUM_SRC_MAX = 8;

   // Ceiling log2 with a floor of 1 bit so single-value fields stay legal.
   function automatic int clog2(input int value);
      int bits;
      bits = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            bits = i + 1;
         end
      end
      return (bits < 1) ? 1 : bits;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority selector: first set request at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever req is nonzero.
//
// Ports:
//   req        request vector, one bit per source
//   ptr        index where the search starts
//   gnt_onehot one-hot winner (all zero when req is zero)
//   gnt_idx    binary index of the winner (0 when req is zero)
module rr_priority_pick
   import axis_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt_onehot,
   output logic [IW-1:0] gnt_idx
);

   logic found;
   int   pos;

   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      found      = 1'b0;
      pos        = 0;
      for (int k = 0; k < N; k++) begin
         pos = (int'(ptr) + k) % N;
         if (!found && req[pos]) begin
            found           = 1'b1;
            gnt_onehot[pos] = 1'b1;
            gnt_idx         = IW'(pos);
         end
      end
   end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter muxing NUM_SRC AXI-Stream sources onto m00.
// Latency: 1 cycle arbitration (IDLE->BUSY), 1 cycle forwarding through the output register.
// Backpressure: granted s_axis_tready = m00_axis_tready | ~m00_axis_tvalid; others held low.
//
// Ports:
//   axis_aclk / axis_areset     clock, synchronous active-high reset
//   src_enable                  per-source eligibility mask (checked only at arbitration)
//   s_axis_*                    packed source streams, source i at slice i
//   m00_axis_*                  registered output stream
//   grant_id                    current / most recent grant
//   busy                        high while a grant is held
//   forced_last                 one-cycle pulse after a grant ends on the beat limit
module axis_rr_arbiter
   import axis_arb_pkg::*;
#(
   parameter  int DATA_SIZE = 32,
   parameter  int NUM_SRC   = 4,
   parameter  int MAX_BEATS = 256,
   localparam int IDW       = clog2(NUM_SRC),
   localparam int CNTW      = clog2(MAX_BEATS + 1),
   localparam int STRBW     = DATA_SIZE / 8
) (
   input  logic                         axis_aclk,
   input  logic                         axis_areset,
   input  logic [NUM_SRC-1:0]           src_enable,
   input  logic [NUM_SRC*DATA_SIZE-1:0] s_axis_tdata,
   input  logic [NUM_SRC*STRBW-1:0]     s_axis_tstrb,
   input  logic [NUM_SRC-1:0]           s_axis_tvalid,
   input  logic [NUM_SRC-1:0]           s_axis_tlast,
   output logic [NUM_SRC-1:0]           s_axis_tready,
   output logic [DATA_SIZE-1:0]         m00_axis_tdata,
   output logic [STRBW-1:0]             m00_axis_tstrb,
   output logic                         m00_axis_tvalid,
   output logic                         m00_axis_tlast,
   input  logic                         m00_axis_tready,
   output logic [IDW-1:0]               grant_id,
   output logic                         busy,
   output logic                         forced_last
);

   arb_state_t          state_q;
   arb_state_t          state_d;
   logic [IDW-1:0]      grant_q;
   logic [IDW-1:0]      rr_ptr;
   logic [IDW-1:0]      pick_idx;
   logic [NUM_SRC-1:0]  req;
   logic [NUM_SRC-1:0]  pick_onehot;
   logic                req_any;
   logic [CNTW-1:0]     beat_cnt_q;
   logic                src_rdy;
   logic                src_vld;
   logic                src_last;
   logic                src_hs;
   logic                at_max;
   logic                release_beat;
   logic                forced_last_q;

   // ---------------- arbitration ----------------
   assign req    = s_axis_tvalid & src_enable;
   assign rr_ptr = (grant_q == IDW'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;

   rr_priority_pick #(
      .N  (NUM_SRC),
      .IW (IDW)
   ) u_pick (
      .req        (req),
      .ptr        (rr_ptr),
      .gnt_onehot (pick_onehot),
      .gnt_idx    (pick_idx)
   );

   assign req_any = |pick_onehot;

   // ---------------- granted-source view ----------------
   assign src_vld  = s_axis_tvalid[grant_q];
   assign src_last = s_axis_tlast[grant_q];
   // Output register can take a beat when empty or draining this cycle.
   assign src_rdy  = (state_q == BUSY) && (m00_axis_tready || !m00_axis_tvalid);
   assign src_hs   = src_rdy && src_vld;
   // Counter holds beats already accepted, so this beat is number MAX_BEATS.
   assign at_max       = (beat_cnt_q == CNTW'(MAX_BEATS - 1));
   assign release_beat = src_hs && (src_last || at_max);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge axis_aclk) begin
      if (axis_areset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_any)      state_d = BUSY;
         BUSY:    if (release_beat) state_d = IDLE;
         default:                   state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      s_axis_tready          = '0;
      s_axis_tready[grant_q] = src_rdy;
      busy                   = (state_q == BUSY);
   end

   // ---------------- grant and beat count ----------------
   always_ff @(posedge axis_aclk) begin
      if (axis_areset) begin
         grant_q    <= IDW'(NUM_SRC - 1);
         beat_cnt_q <= '0;
      end else if (state_q == IDLE) begin
         if (req_any) begin
            grant_q    <= pick_idx;
            beat_cnt_q <= '0;
         end
      end else if (src_hs) begin
         beat_cnt_q <= beat_cnt_q + 1'b1;
      end
   end

   // ---------------- registered output stage ----------------
   always_ff @(posedge axis_aclk) begin
      if (axis_areset) begin
         m00_axis_tdata  <= '0;
         m00_axis_tstrb  <= '0;
         m00_axis_tvalid <= 1'b0;
         m00_axis_tlast  <= 1'b0;
         forced_last_q   <= 1'b0;
      end else begin
         forced_last_q <= 1'b0;
         if (src_hs) begin
            m00_axis_tdata  <= s_axis_tdata[int'(grant_q) * DATA_SIZE +: DATA_SIZE];
            m00_axis_tstrb  <= s_axis_tstrb[int'(grant_q) * STRBW +: STRBW];
            m00_axis_tvalid <= 1'b1;
            // A packet longer than the limit is cut here; the rest re-arbitrates.
            m00_axis_tlast  <= src_last || at_max;
            forced_last_q   <= at_max && !src_last;
         end else if (m00_axis_tvalid && m00_axis_tready) begin
            m00_axis_tvalid <= 1'b0;
         end
      end
   end

   assign grant_id    = grant_q;
   assign forced_last = forced_last_q;

endmodule
